// File: rtl/gerador_frequencia_if.sv
// Control/status bundle of the square-wave generator: BCD load request, enable,
// and the generated wave with its load status.
interface gerador_frequencia_if;
    logic        carregar;
    logic [3:0]  dig_5;
    logic [3:0]  dig_4;
    logic [3:0]  dig_3;
    logic [3:0]  dig_2;
    logic [3:0]  dig_1;
    logic        habilitar;
    logic        saida;
    logic        ocupado;
    logic        erro;
    logic [16:0] freq_ativa;

    modport master (
        output carregar, dig_5, dig_4, dig_3, dig_2, dig_1, habilitar,
        input  saida, ocupado, erro, freq_ativa
    );

    modport slave (
        input  carregar, dig_5, dig_4, dig_3, dig_2, dig_1, habilitar,
        output saida, ocupado, erro, freq_ativa
    );
endinterface

// File: rtl/gerador_frequencia.sv
// Square-wave generator: five BCD digits (Hz) are converted to binary over five
// cycles, validated, then drive a fractional accumulator that toggles saida.
module gerador_frequencia #(
    parameter int unsigned CLK_HZ = 1000000,
    parameter int unsigned ACC_W  = 21
) (
    input  logic                  clk,
    input  logic                  limpar_n,
    gerador_frequencia_if.slave   bus
);

    typedef enum logic [1:0] {
        OCIOSO,
        CONVERTE,
        VALIDA
    } estado_t;

    localparam logic [ACC_W:0] LIMITE = (ACC_W+1)'(CLK_HZ);

    estado_t          estado_q;
    logic [2:0]       idx_q;
    logic [19:0]      digs_q;
    logic             inv_q;
    logic [16:0]      bin_q;
    logic [16:0]      bin_d;
    logic             ocupado_q;
    logic             erro_q;
    logic [16:0]      freq_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             saida_q;
    logic             saida_d;
    logic [ACC_W:0]   soma;
    logic             aceita;

    // Captured digits shift left one nibble per step, so the next digit is always on top.
    always_comb begin
        bin_d  = 17'(bin_q * 17'd10) + {13'd0, digs_q[19:16]};
        aceita = (estado_q == VALIDA) && !inv_q && ((32'(bin_q) << 1) <= CLK_HZ);
    end

    // One extra bit on the sum keeps the threshold compare free of wrap-around.
    always_comb begin
        soma    = {1'b0, acc_q} + (ACC_W+1)'({freq_q, 1'b0});
        acc_d   = '0;
        saida_d = 1'b0;
        if (bus.habilitar && (freq_q != '0)) begin
            if (aceita) begin
                acc_d   = '0;
                saida_d = saida_q;
            end else if (soma >= LIMITE) begin
                acc_d   = ACC_W'(soma - LIMITE);
                saida_d = ~saida_q;
            end else begin
                acc_d   = soma[ACC_W-1:0];
                saida_d = saida_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge limpar_n) begin
        if (!limpar_n) begin
            estado_q  <= OCIOSO;
            idx_q     <= '0;
            digs_q    <= '0;
            inv_q     <= 1'b0;
            bin_q     <= '0;
            ocupado_q <= 1'b0;
            erro_q    <= 1'b0;
            freq_q    <= '0;
            acc_q     <= '0;
            saida_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            saida_q <= saida_d;
            unique case (estado_q)
                OCIOSO: begin
                    if (bus.carregar) begin
                        digs_q    <= {bus.dig_5, bus.dig_4, bus.dig_3, bus.dig_2, bus.dig_1};
                        inv_q     <= (bus.dig_5 > 4'd9) || (bus.dig_4 > 4'd9) ||
                                     (bus.dig_3 > 4'd9) || (bus.dig_2 > 4'd9) ||
                                     (bus.dig_1 > 4'd9);
                        bin_q     <= '0;
                        idx_q     <= 3'd5;
                        ocupado_q <= 1'b1;
                        estado_q  <= CONVERTE;
                    end
                end
                CONVERTE: begin
                    bin_q  <= bin_d;
                    digs_q <= {digs_q[15:0], 4'd0};
                    idx_q  <= idx_q - 3'd1;
                    if (idx_q == 3'd1) begin
                        estado_q <= VALIDA;
                    end
                end
                VALIDA: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= OCIOSO;
                    if (aceita) begin
                        freq_q <= bin_q;
                        erro_q <= 1'b0;
                    end else begin
                        erro_q <= 1'b1;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign bus.saida      = saida_q;
    assign bus.ocupado    = ocupado_q;
    assign bus.erro       = erro_q;
    assign bus.freq_ativa = freq_q;

endmodule

// File: tb/tb_gerador_frequencia.sv
// Directed self-checking bench for gerador_frequencia at CLK_HZ=1000; inputs
// change and outputs are sampled on the falling clock edge.
module tb_gerador_frequencia;

    localparam int unsigned CLK_HZ = 1000;

    logic clk;
    logic limpar_n;
    int   checks;
    int   failures;

    gerador_frequencia_if bus ();

    gerador_frequencia #(.CLK_HZ(CLK_HZ), .ACC_W(21)) dut (
        .clk      (clk),
        .limpar_n (limpar_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Issues a one-cycle carregar pulse and waits (bounded) for ocupado to drop.
    task automatic load(input logic [3:0] d5, d4, d3, d2, d1, output int busy);
        bus.dig_5 = d5; bus.dig_4 = d4; bus.dig_3 = d3; bus.dig_2 = d2; bus.dig_1 = d1;
        bus.carregar = 1'b1;
        @(negedge clk);
        bus.carregar = 1'b0;
        busy = 0;
        while (bus.ocupado === 1'b1 && busy < 20) begin
            busy++;
            @(negedge clk);
        end
    endtask

    // Observes saida for n cycles: toggle count, first-toggle cycle, min/max half-period.
    task automatic measure(input int n, output int tog, output int first,
                           output int lo, output int hi);
        logic prev;
        int   last;
        prev  = bus.saida;
        last  = 0;
        tog   = 0;
        first = -1;
        lo    = 1 << 30;
        hi    = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (bus.saida !== prev) begin
                tog++;
                if (first < 0) begin
                    first = k;
                end else begin
                    if (k - last < lo) lo = k - last;
                    if (k - last > hi) hi = k - last;
                end
                last = k;
                prev = bus.saida;
            end
        end
    endtask

    task automatic test_reset();
        limpar_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.saida, bus.ocupado, bus.erro} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b expected=000", {bus.saida, bus.ocupado, bus.erro});
        end
        checks++;
        if (bus.freq_ativa !== 17'd0) begin
            failures++;
            $display("FAIL reset_freq got=%0d expected=0", bus.freq_ativa);
        end
        limpar_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_250();
        int busy, tog, first, lo, hi;
        bus.habilitar = 1'b1;
        load(4'd0, 4'd0, 4'd2, 4'd5, 4'd0, busy);
        checks++;
        if (busy !== 6) begin
            failures++;
            $display("FAIL busy_cycles got=%0d expected=6", busy);
        end
        checks++;
        if (bus.freq_ativa !== 17'd250 || bus.erro !== 1'b0) begin
            failures++;
            $display("FAIL load_250 freq=%0d erro=%b expected freq=250 erro=0", bus.freq_ativa, bus.erro);
        end
        measure(16, tog, first, lo, hi);
        checks++;
        if (first !== 2 || tog !== 8 || lo !== 2 || hi !== 2) begin
            failures++;
            $display("FAIL wave_250 first=%0d tog=%0d lo=%0d hi=%0d expected 2/8/2/2", first, tog, lo, hi);
        end
    endtask

    task automatic test_invalid();
        int busy, tog, first, lo, hi;
        load(4'd0, 4'd0, 4'd2, 4'hA, 4'd0, busy);
        checks++;
        if (busy !== 6 || bus.erro !== 1'b1 || bus.freq_ativa !== 17'd250) begin
            failures++;
            $display("FAIL bad_digit busy=%0d erro=%b freq=%0d expected 6/1/250", busy, bus.erro, bus.freq_ativa);
        end
        measure(16, tog, first, lo, hi);
        checks++;
        if (tog !== 8 || lo !== 2 || hi !== 2) begin
            failures++;
            $display("FAIL wave_after_bad tog=%0d lo=%0d hi=%0d expected 8/2/2", tog, lo, hi);
        end
        load(4'd0, 4'd0, 4'd5, 4'd0, 4'd1, busy);
        checks++;
        if (bus.erro !== 1'b1 || bus.freq_ativa !== 17'd250) begin
            failures++;
            $display("FAIL over_range erro=%b freq=%0d expected 1/250", bus.erro, bus.freq_ativa);
        end
        load(4'd0, 4'd0, 4'd5, 4'd0, 4'd0, busy);
        checks++;
        if (bus.erro !== 1'b0 || bus.freq_ativa !== 17'd500) begin
            failures++;
            $display("FAIL max_freq erro=%b freq=%0d expected 0/500", bus.erro, bus.freq_ativa);
        end
        measure(16, tog, first, lo, hi);
        checks++;
        if (first !== 1 || tog !== 16 || lo !== 1 || hi !== 1) begin
            failures++;
            $display("FAIL wave_500 first=%0d tog=%0d lo=%0d hi=%0d expected 1/16/1/1", first, tog, lo, hi);
        end
    endtask

    task automatic test_slow();
        int busy, tog, first, lo, hi;
        load(4'd0, 4'd0, 4'd0, 4'd0, 4'd3, busy);
        checks++;
        if (bus.freq_ativa !== 17'd3) begin
            failures++;
            $display("FAIL load_3 got=%0d expected=3", bus.freq_ativa);
        end
        measure(1000, tog, first, lo, hi);
        checks++;
        if (first !== 167 || tog !== 6 || lo < 166 || hi > 167) begin
            failures++;
            $display("FAIL wave_3_w1 first=%0d tog=%0d lo=%0d hi=%0d expected 167/6/166..167", first, tog, lo, hi);
        end
        measure(1000, tog, first, lo, hi);
        checks++;
        if (tog !== 6 || lo < 166 || hi > 167) begin
            failures++;
            $display("FAIL wave_3_w2 tog=%0d lo=%0d hi=%0d expected 6/166..167", tog, lo, hi);
        end
    endtask

    task automatic test_back_to_back();
        int busy;
        bus.dig_5 = 4'd0; bus.dig_4 = 4'd0; bus.dig_3 = 4'd2; bus.dig_2 = 4'd5; bus.dig_1 = 4'd0;
        bus.carregar = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ocupado !== 1'b1) begin
            failures++;
            $display("FAIL b2b_start ocupado=%b expected=1", bus.ocupado);
        end
        repeat (2) @(negedge clk);
        bus.dig_3 = 4'd5; bus.dig_2 = 4'd0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.ocupado !== 1'b0 || bus.freq_ativa !== 17'd250) begin
            failures++;
            $display("FAIL b2b_first ocupado=%b freq=%0d expected 0/250", bus.ocupado, bus.freq_ativa);
        end
        @(negedge clk);
        checks++;
        if (bus.ocupado !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_start ocupado=%b expected=1", bus.ocupado);
        end
        bus.carregar = 1'b0;
        busy = 0;
        while (bus.ocupado === 1'b1 && busy < 20) begin
            busy++;
            @(negedge clk);
        end
        checks++;
        if (busy !== 6 || bus.freq_ativa !== 17'd500) begin
            failures++;
            $display("FAIL b2b_second busy=%0d freq=%0d expected 6/500", busy, bus.freq_ativa);
        end
        bus.habilitar = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.saida !== 1'b0 || bus.freq_ativa !== 17'd500) begin
            failures++;
            $display("FAIL disable saida=%b freq=%0d expected 0/500", bus.saida, bus.freq_ativa);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bus.saida !== 1'b0) begin
            failures++;
            $display("FAIL disable_hold saida=%b expected=0", bus.saida);
        end
    endtask

    task automatic test_reset_mid();
        logic seen_high;
        bus.habilitar = 1'b1;
        repeat (3) @(negedge clk);
        bus.dig_5 = 4'd0; bus.dig_4 = 4'd0; bus.dig_3 = 4'd1; bus.dig_2 = 4'd0; bus.dig_1 = 4'd0;
        bus.carregar = 1'b1;
        @(negedge clk);
        bus.carregar = 1'b0;
        repeat (2) @(negedge clk);
        #2 limpar_n = 1'b0;
        #1;
        checks++;
        if ({bus.saida, bus.ocupado, bus.erro} !== 3'b000 || bus.freq_ativa !== 17'd0) begin
            failures++;
            $display("FAIL async_reset flags=%b freq=%0d expected 000/0",
                     {bus.saida, bus.ocupado, bus.erro}, bus.freq_ativa);
        end
        @(negedge clk);
        limpar_n = 1'b1;
        seen_high = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.saida !== 1'b0 || bus.ocupado !== 1'b0) seen_high = 1'b1;
        end
        checks++;
        if (seen_high !== 1'b0 || bus.freq_ativa !== 17'd0) begin
            failures++;
            $display("FAIL reset_abort activity=%b freq=%0d expected 0/0", seen_high, bus.freq_ativa);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        limpar_n      = 1'b0;
        bus.carregar  = 1'b0;
        bus.habilitar = 1'b0;
        bus.dig_5 = 4'd0; bus.dig_4 = 4'd0; bus.dig_3 = 4'd0; bus.dig_2 = 4'd0; bus.dig_1 = 4'd0;
        @(negedge clk);
        test_reset();
        test_load_250();
        test_invalid();
        test_slow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
